alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
// - Shares one 64-bit combinational ALU between NREQ requesters (e.g. execute stage, address-gen unit).
// - Round-robin grant; operands and cntrl are registered into the ALU and held ALU_LAT cycles for gate-delay settling.
// - Result and flags {negative, zero, overflow, carry_out} are captured and returned to the granted requester.
// PARAMETERS
// - NREQ     2   number of requesters (2..4)
// - WIDTH    64  operand/result width
// - ALU_LAT  2   cycles operands are held before result capture (>=1)
// PORTS
// - clk          in   1           rising-edge clock
// - reset_n      in   1           asynchronous, active-low reset
// - req_valid    in   NREQ        requester i has an op pending
// - req_ready    out  NREQ        one-hot grant; op i accepted when req_valid[i]&req_ready[i]
// - req_a        in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
// - req_b        in   NREQ*WIDTH  operand B, same packing
// - req_cntrl    in   NREQ*3      ALU op: 000 B, 010 add, 011 sub, 100 and, 101 or, 110 xor
// - alu_a        out  WIDTH       registered operand A to ALU
// - alu_b        out  WIDTH       registered operand B to ALU
// - alu_cntrl    out  3           registered op to ALU
// - alu_result   in   WIDTH       ALU result
// - alu_flags    in   4           ALU {negative, zero, overflow, carry_out}
// - rsp_valid    out  NREQ        one-hot; response for requester i available
// - rsp_ready    in   NREQ        requester i consumes response
// - rsp_result   out  WIDTH       captured result
// - rsp_flags    out  4           captured flags, same order as alu_flags
// BEHAVIOUR
// - States: IDLE, EXEC, RESP. Reset (async, reset_n=0): state IDLE, rr pointer=0, req_ready=0,
//   rsp_valid=0, alu_a/alu_b/rsp_result=0, alu_cntrl=000, rsp_flags=0, exec counter=0.
// - IDLE: winner = first i with req_valid[i], scanning ptr, ptr+1, ... mod NREQ. req_ready is
//   combinational, asserted only in IDLE and only for the winner; zero if no req_valid.
// - On accept edge: alu_a/b/cntrl <= winner's operands, owner <= winner, ptr <= (winner+1) mod NREQ,
//   counter <= ALU_LAT-1, state -> EXEC. ptr unchanged when nothing accepted.
// - EXEC: alu_* held stable; counter decrements each cycle; when counter==0, rsp_result <= alu_result,
//   rsp_flags <= alu_flags, state -> RESP. Accept-to-rsp_valid latency = ALU_LAT+1 cycles
//   (ALU_LAT=2: accept edge 0, rsp_valid high after edge 2... visible cycle 3).
// - RESP: rsp_valid[owner]=1, others 0; rsp_result/flags stable until rsp_ready[owner]. On
//   rsp_valid&rsp_ready edge -> IDLE; rsp_valid drops next cycle. rsp_ready of non-owners ignored.
// - One op in flight max: req_ready=0 in EXEC and RESP; no grant in the handshake-completion cycle
//   (next grant earliest one cycle after response consumed). Throughput: 1 op / (ALU_LAT+2) cycles.
// - Simultaneous req_valid: round-robin; a continuously requesting port waits at most NREQ-1 grants.
// - req_valid may drop before grant; no state change. Operands sampled only on the accept edge.
// - Unused cntrl codes (001, 111) forwarded unchanged; result/flags are whatever the ALU returns.
// - Flags returned verbatim; overflow/carry meaningful only for 010/011 (ALU-defined).
// - alu_* outputs keep last op's values in IDLE/RESP (no re-zeroing), so ALU inputs toggle only on accept.
// - reset_n asserted mid-EXEC/RESP: in-flight op dropped, no response, all outputs to reset values
//   immediately (asynchronous); requester must reissue.
// TESTING
// - Single op: req 0 valid, A=5, B=3, cntrl=010, rsp_ready=1 -> req_ready[0] in cycle 0;
//   rsp_valid[0] at ALU_LAT+1 cycles later, rsp_result=8, rsp_flags=0000.
// - Sub flags: A=0, B=1, cntrl=011 -> rsp_result=64'hFFFF_FFFF_FFFF_FFFF, negative=1, zero=0, carry_out=0;
//   A=B=7 sub -> result 0, zero=1, carry_out=1.
// - Fairness: both ports valid continuously, 6 ops -> grants alternate 0,1,0,1,0,1; each rsp routed
//   to correct rsp_valid bit with its own result (port0 A+B, port1 A^B).
// - Backpressure: hold rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid/result stable, req_ready=0
//   for port 1 throughout; port 1 granted exactly one cycle after port 0 handshake.
// - Overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, add -> result 64'h8000_..._0000, negative=1, overflow=1.
// - Reset mid-EXEC: drop reset_n one cycle after accept -> all outputs 0 immediately, state IDLE,
//   no rsp_valid after release; ptr=0 so port 0 wins next tie.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// One op in flight: operands are held ALU_LAT cycles, then result/flags are returned to the owner.
module alu_share_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_cntrl,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_cntrl,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic [3:0]            alu_flags,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [3:0]            rsp_flags
);

    localparam int unsigned PW = (NREQ > 2) ? 2 : 1;
    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  alu_a_d, alu_b_d, rsp_result_d;
    logic [2:0]        alu_cntrl_d;
    logic [3:0]        rsp_flags_d;
    logic [NREQ-1:0]   rsp_valid_d;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW:0]       scan_idx;

    // Round-robin scan starting at ptr_q, wrapping modulo NREQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NREQ)) begin
                scan_idx = scan_idx - (PW+1)'(NREQ);
            end
            if (!win_found && req_valid[scan_idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset_n && (state_q == IDLE) && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_cntrl_d  = alu_cntrl;
        rsp_result_d = rsp_result;
        rsp_flags_d  = rsp_flags;
        rsp_valid_d  = rsp_valid;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (win_idx == PW'(i)) begin
                            alu_a_d     = req_a[i*WIDTH +: WIDTH];
                            alu_b_d     = req_b[i*WIDTH +: WIDTH];
                            alu_cntrl_d = req_cntrl[i*3 +: 3];
                        end
                    end
                    owner_d = win_idx;
                    ptr_d   = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                    cnt_d   = CW'(ALU_LAT-1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_result_d         = alu_result;
                    rsp_flags_d          = alu_flags;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Only the owner's rsp_ready completes the handshake
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cntrl  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_valid  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_cntrl  <= alu_cntrl_d;
            rsp_result <= rsp_result_d;
            rsp_flags  <= rsp_flags_d;
            rsp_valid  <= rsp_valid_d;
        end
    end

endmodule
